// File: rtl/arbitro_comparador_pkg.sv
// Shared types and constants for the round-robin comparator scheduler.
package arbitro_comparador_pkg;

   localparam int unsigned CMP_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } estado_t;

   localparam logic SEL_IGUAL     = 1'b0;
   localparam logic SEL_DIFERENTE = 1'b1;

   typedef struct packed {
      logic [CMP_W-1:0] a;
      logic [CMP_W-1:0] b;
      logic             sel;
   } operandos_t;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: first set req bit scanning from ptr upward, wrapping.
module arbitro_rr #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   winner_c,
   output logic             any_req_c
);

   always_comb begin
      logic         found;
      int unsigned  idx;
      found    = 1'b0;
      idx      = 0;
      winner_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[IDW'(idx)]) begin
            winner_c = IDW'(idx);
            found    = 1'b1;
         end
      end
   end

   assign any_req_c = |req;

endmodule

// File: rtl/comparador_igual_diferente.sv
// 3-bit equal/different comparator; sel picks which relation is reported.
module comparador_igual_diferente
   import arbitro_comparador_pkg::*;
(
   input  logic [CMP_W-1:0] a,
   input  logic [CMP_W-1:0] b,
   input  logic             sel,
   output logic             resultado_c
);

   logic igual_c;

   assign igual_c     = (a == b);
   assign resultado_c = (sel == SEL_DIFERENTE) ? ~igual_c : igual_c;

endmodule

// File: rtl/arbitro_comparador.sv
// Round-robin scheduler sharing one comparator among N_REQ requesters; result tagged with index.
module arbitro_comparador
   import arbitro_comparador_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 3,
   parameter int unsigned IDW   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_in,
   input  logic [N_REQ*WIDTH-1:0] b_in,
   input  logic [N_REQ-1:0]       sel_in,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   done,
   output logic                   resultado,
   output logic [IDW-1:0]         done_id
);

   estado_t          state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win_q;
   logic [IDW-1:0]   winner_c;
   logic             any_req_c;
   operandos_t       ops;
   operandos_t       ops_sel_c;
   logic             cmp_c;

   arbitro_rr #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
      .req       (req),
      .ptr       (ptr),
      .winner_c  (winner_c),
      .any_req_c (any_req_c)
   );

   comparador_igual_diferente u_cmp (
      .a           (ops.a),
      .b           (ops.b),
      .sel         (ops.sel),
      .resultado_c (cmp_c)
   );

   // Operand slice of the granted requester, selected with constant indices only.
   always_comb begin
      ops_sel_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (IDW'(i) == win_q) begin
            ops_sel_c.a   = a_in[i*WIDTH +: WIDTH];
            ops_sel_c.b   = b_in[i*WIDTH +: WIDTH];
            ops_sel_c.sel = sel_in[i];
         end
      end
   end

   // done_id is loaded alongside resultado so both hold until the next DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         win_q     <= '0;
         ops       <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         resultado <= 1'b0;
         done_id   <= '0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req_c) begin
                  win_q <= winner_c;
                  gnt   <= N_REQ'(1) << winner_c;
                  busy  <= 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               ops   <= ops_sel_c;
               ptr   <= (win_q == IDW'(N_REQ - 1)) ? '0 : win_q + IDW'(1);
               state <= COMPARE;
            end
            COMPARE: begin
               resultado <= cmp_c;
               done_id   <= win_q;
               done      <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_comparador.sv
// Directed bench for arbitro_comparador: reset, modes, fairness, ptr priority, mid-op reset, operand hold.
module tb_arbitro_comparador;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] a_in;
   logic [11:0] b_in;
   logic [3:0]  sel_in;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic        resultado;
   logic [1:0]  done_id;

   int errors = 0;
   int checks = 0;

   arbitro_comparador #(.N_REQ(4), .WIDTH(3), .IDW(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .sel_in    (sel_in),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .resultado (resultado),
      .done_id   (done_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic set_ops(input int i, input logic [2:0] a, input logic [2:0] b, input logic s);
      a_in[i*3 +: 3] = a;
      b_in[i*3 +: 3] = b;
      sel_in[i]      = s;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (resultado !== 1'b0) begin errors++; $display("FAIL reset_resultado got=%b exp=0", resultado); end
      checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      set_ops(0, 3'b101, 3'b101, 1'b0);
      req = 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
      req = 4'b0000;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL single_gnt_pulse gnt=%b done=%b exp 0000/0", gnt, done); end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", done); end
      checks++; if (resultado !== 1'b1) begin errors++; $display("FAIL single_resultado got=%b exp=1", resultado); end
      checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL single_done_id got=%0d exp=0", done_id); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end done=%b busy=%b exp 0/0", done, busy); end
   endtask

   task automatic test_mode();
      logic [1:0] sel_cases;
      logic [1:0] exp_res;
      sel_cases = 2'b01;
      exp_res   = 2'b01;
      for (int k = 1; k >= 0; k--) begin
         set_ops(1, 3'b001, 3'b010, sel_cases[k]);
         req = 4'b0010;
         @(negedge clk);
         checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mode%0d_gnt got=%b exp=0010", k, gnt); end
         req = 4'b0000;
         @(negedge clk);
         @(negedge clk);
         checks++; if (done !== 1'b1 || resultado !== exp_res[k] || done_id !== 2'd1) begin
            errors++; $display("FAIL mode%0d_result done=%b res=%b id=%0d exp 1/%b/1", k, done, resultado, done_id, exp_res[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_res;
      time        last_t;
      int         cnt;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      set_ops(0, 3'd3, 3'd3, 1'b0);
      set_ops(1, 3'd3, 3'd3, 1'b1);
      set_ops(2, 3'd7, 3'd0, 1'b1);
      set_ops(3, 3'd7, 3'd0, 1'b0);
      exp_res = 4'b0101;
      req = 4'b1111;
      last_t = 0;
      for (int g = 0; g < 5; g++) begin
         logic [3:0] eg;
         int         e;
         e  = g % 4;
         eg = 4'b0001 << e;
         cnt = 0;
         @(negedge clk);
         while (gnt === 4'b0000 && cnt < 10) begin
            @(negedge clk);
            cnt++;
         end
         checks++; if (gnt !== eg) begin errors++; $display("FAIL fair%0d_gnt got=%b exp=%b", g, gnt, eg); end
         if (g > 0) begin
            checks++; if ($time - last_t != 40) begin errors++; $display("FAIL fair%0d_spacing got=%0t exp=40", g, $time - last_t); end
         end
         last_t = $time;
         @(negedge clk);
         @(negedge clk);
         if (g == 4) req = 4'b0000;
         checks++; if (done !== 1'b1 || done_id !== 2'(e) || resultado !== exp_res[e]) begin
            errors++; $display("FAIL fair%0d_done done=%b id=%0d res=%b exp 1/%0d/%b", g, done, done_id, resultado, e, exp_res[e]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_priority();
      req = 4'b0100;
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL prio_first_gnt got=%b exp=0100", gnt); end
      req = 4'b0000;
      repeat (3) @(negedge clk);
      req = 4'b0101;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL prio_gnt got=%b exp=0001", gnt); end
      req = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int dones;
      req = 4'b0010;
      @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || resultado !== 1'b1) begin errors++; $display("FAIL midrst_pre busy=%b res=%b exp 1/1", busy, resultado); end
      reset = 1'b1;
      #1;
      checks++; if ({gnt, busy, done, resultado, done_id} !== 9'd0) begin
         errors++; $display("FAIL midrst_clear gnt=%b busy=%b done=%b res=%b id=%0d exp all 0", gnt, busy, done, resultado, done_id);
      end
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
      req = 4'b1000;
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL midrst_gnt got=%b exp=1000", gnt); end
      req = 4'b0000;
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1 || done_id !== 2'd3 || resultado !== 1'b0) begin
         errors++; $display("FAIL midrst_done done=%b id=%0d res=%b exp 1/3/0", done, done_id, resultado);
      end
      @(negedge clk);
   endtask

   task automatic test_operand_stability();
      set_ops(2, 3'd5, 3'd5, 1'b0);
      req = 4'b0100;
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stab_gnt got=%b exp=0100", gnt); end
      req = 4'b0000;
      @(negedge clk);
      set_ops(2, 3'd1, 3'd6, 1'b0);
      @(negedge clk);
      checks++; if (done !== 1'b1 || done_id !== 2'd2 || resultado !== 1'b1) begin
         errors++; $display("FAIL stab_done done=%b id=%0d res=%b exp 1/2/1", done, done_id, resultado);
      end
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      req    = 4'b0000;
      a_in   = '0;
      b_in   = '0;
      sel_in = '0;
      test_reset();
      test_single();
      test_mode();
      test_fairness();
      test_priority();
      test_reset_mid_op();
      test_operand_stability();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
